// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: FSM state and frame command encodings shared by the SPI RAM slave.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

  // Top two frame bits.
  typedef enum logic [1:0] {
    CmdWrAddr = 2'b00,
    CmdWrData = 2'b01,
    CmdRdAddr = 2'b10,
    CmdRdData = 2'b11
  } cmd_e;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: single-port RAM, synchronous write, one-cycle registered read.
// Addresses at or beyond MEM_DEPTH are ignored on write and read back as zero.
module spi_ram_mem #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_SIZE-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  in_range;

  assign in_range = 32'(addr_i) < MEM_DEPTH;

  // Storage array and registered read port; no reset so contents survive rst.
  always_ff @(posedge clk_i) begin
    if (we_i && in_range) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= in_range ? mem_q[addr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_burst_slave.sv
// spi_ram_burst_slave: SPI-framed RAM slave. A frame is a 2-bit command followed by a
// DATA_WIDTH payload, shifted in MSB first while SS_n is low. A read-data frame answers
// on MISO after one turnaround cycle.
// Optional feature: define SPI_RAM_AUTOINC_EN for pointer post-increment and streaming reads.
module spi_ram_burst_slave
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int unsigned FrameLen = DATA_WIDTH + 2;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);
  localparam int unsigned TxCntW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameLen);

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [FrameLen-1:0]   rx_q, rx_d;
  logic                  done_q, done_d;       // frame consumed, idle until deselect
  logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_issue_q, rd_issue_d; // RAM read launched last cycle
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [TxCntW-1:0]     tx_cnt_q, tx_cnt_d;
  logic                  miso_q, miso_d;

  cmd_e                  cmd;
  logic                  mem_we, mem_re;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    if (32'(p) >= MEM_DEPTH - 1) return '0;
    return p + ADDR_SIZE'(1);
  endfunction

  assign cmd = cmd_e'(rx_q[FrameLen-1 -: 2]);

  // Next-state: frame shifting, command commit and MISO serialisation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    done_d     = done_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_pend_d  = rd_pend_q;
    rd_issue_d = 1'b0;
    tx_d       = tx_q;
    tx_cnt_d   = tx_cnt_q;
    miso_d     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = rd_ptr_q;

    if (SS_n) begin
      state_d  = StIdle;
      cnt_d    = '0;
      done_d   = 1'b0;
      tx_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StChkCmd;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
        StChkCmd: begin
          rx_d    = {rx_q[FrameLen-2:0], MOSI};
          cnt_d   = CntW'(1);
          state_d = MOSI ? (rd_pend_q ? StReadData : StReadAdd) : StWrite;
        end
        default: begin
          if (!done_q) begin
            if (cnt_q != CntFull) begin
              rx_d  = {rx_q[FrameLen-2:0], MOSI};
              cnt_d = cnt_q + CntW'(1);
            end else begin
              done_d = 1'b1;
              unique case (cmd)
                CmdWrAddr: wr_ptr_d = rx_q[ADDR_SIZE-1:0];
                CmdWrData: begin
                  mem_we   = 1'b1;
                  mem_addr = wr_ptr_q;
                  if (AutoInc) wr_ptr_d = ptr_inc(wr_ptr_q);
                end
                CmdRdAddr: begin
                  // A read-address arriving with a read already pending is dropped.
                  if (state_q == StReadAdd) begin
                    rd_ptr_d  = rx_q[ADDR_SIZE-1:0];
                    rd_pend_d = 1'b1;
                  end
                end
                CmdRdData: begin
                  if (state_q == StReadData) begin
                    mem_re     = 1'b1;
                    rd_issue_d = 1'b1;
                    rd_pend_d  = AutoInc;
                    if (AutoInc) rd_ptr_d = ptr_inc(rd_ptr_q);
                  end
                end
              endcase
            end
          end
        end
      endcase

      // The registered read lands one cycle after launch; that cycle is the turnaround.
      if (rd_issue_q) begin
        miso_d   = mem_rdata[DATA_WIDTH-1];
        tx_d     = {mem_rdata[DATA_WIDTH-2:0], 1'b0};
        tx_cnt_d = TxCntW'(DATA_WIDTH - 1);
      end else if (tx_cnt_q != '0) begin
        miso_d   = tx_q[DATA_WIDTH-1];
        tx_d     = {tx_q[DATA_WIDTH-2:0], 1'b0};
        tx_cnt_d = tx_cnt_q - TxCntW'(1);
      end
    end
  end

  // State registers with synchronous reset; RAM contents are not touched by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rx_q       <= '0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_issue_q <= 1'b0;
      tx_q       <= '0;
      tx_cnt_q   <= '0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_issue_q <= rd_issue_d;
      tx_q       <= tx_d;
      tx_cnt_q   <= tx_cnt_d;
      miso_q     <= miso_d;
    end
  end

  assign MISO = miso_q;

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we & ~rst),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(rx_q[DATA_WIDTH-1:0]),
    .rdata_o(mem_rdata)
  );

endmodule
